aes_round_ctrl: RTL

Iterative AES-128 cipher round sequencer. It accepts a 128-bit plaintext over a valid/ready handshake and owns the state register. Over 11 cycles it drives the combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) and the key-schedule index, then returns the ciphertext over a second valid/ready handshake. It sits between the cipher-unit top and the round datapath/key schedule.

---
 rtl/aes_round_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Iterative AES-128 round sequencer. Accepts a 128-bit plaintext,
//            owns the cipher state register, walks the external round
//            datapath through the initial AddRoundKey, NR-1 full rounds and
//            the final round, then presents the ciphertext.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   flush_i     in   synchronous abort, back to IDLE, block discarded
//   in_valid    in   plaintext valid
//   in_ready    out  controller idle, plaintext accepted on in_valid
//   pt_i        in   plaintext, pt_i[0] = bits 127:96
//   rk_idx      out  round-key index requested from the key schedule
//   rk_valid    in   round key for rk_idx is present at the datapath
//   dp_state_o  out  current state to the datapath
//   dp_mode     out  0 AddRoundKey, 1 full round, 2 final round
//   dp_state_i  in   datapath result
//   out_valid   out  ciphertext valid
//   out_ready   in   consumer accepts ciphertext
//   ct_o        out  ciphertext (state register)
//   round_o     out  round counter
//   busy        out  block in flight (ROUND or DONE)
// ============================================================================
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   pt_i [3:0],
  output logic [RW-1:0] rk_idx,
  input  logic          rk_valid,
  output logic [31:0]   dp_state_o [3:0],
  output logic [1:0]    dp_mode,
  input  logic [31:0]   dp_state_i [3:0],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   ct_o [3:0],
  output logic [RW-1:0] round_o,
  output logic          busy
);

  localparam logic [RW-1:0] c_NR         = RW'(NR);
  localparam logic [1:0]    c_MODE_ARK   = 2'd0;
  localparam logic [1:0]    c_MODE_FULL  = 2'd1;
  localparam logic [1:0]    c_MODE_FINAL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_fsm;
  state_t        w_fsm_nxt;
  logic [RW-1:0] r_round;
  logic [RW-1:0] w_round_nxt;
  logic          w_load_pt;
  logic          w_load_dp;
  logic [31:0]   r_state [3:0];
  logic [1:0]    w_mode;

  // Next-state / datapath-load decode
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_round_nxt = r_round;
    w_load_pt   = 1'b0;
    w_load_dp   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          w_fsm_nxt   = S_ROUND;
          w_round_nxt = '0;
          w_load_pt   = 1'b1;
        end
      end
      S_ROUND: begin
        if (r_round > c_NR) begin
          // Unreachable counter value: recover to a clean idle state.
          w_fsm_nxt   = S_IDLE;
          w_round_nxt = '0;
        end else if (rk_valid) begin
          w_load_dp = 1'b1;
          if (r_round == c_NR) begin
            w_fsm_nxt = S_DONE;
          end else begin
            w_round_nxt = r_round + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_round_nxt = '0;
      end
    endcase
    // Abort overrides everything, including a same-cycle accept. The state
    // register keeps whatever it held; only control is reset.
    if (flush_i) begin
      w_fsm_nxt   = S_IDLE;
      w_round_nxt = '0;
      w_load_pt   = 1'b0;
      w_load_dp   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_round <= '0;
      r_state <= '{default: 32'h0};
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_round <= w_round_nxt;
      if (w_load_pt) begin
        r_state <= pt_i;
      end else if (w_load_dp) begin
        r_state <= dp_state_i;
      end
    end
  end

  // Mode depends only on registered state, so a stall holds it naturally.
  always_comb begin
    w_mode = c_MODE_ARK;
    if (r_fsm == S_ROUND) begin
      if (r_round == '0) begin
        w_mode = c_MODE_ARK;
      end else if (r_round == c_NR) begin
        w_mode = c_MODE_FINAL;
      end else begin
        w_mode = c_MODE_FULL;
      end
    end
  end

  assign in_ready   = (r_fsm == S_IDLE);
  assign out_valid  = (r_fsm == S_DONE);
  assign busy       = (r_fsm == S_ROUND) || (r_fsm == S_DONE);
  assign rk_idx     = r_round;
  assign round_o    = r_round;
  assign dp_mode    = w_mode;
  assign dp_state_o = r_state;
  assign ct_o       = r_state;

endmodule
`default_nettype wire
